// File: rtl/riscv_wb_pkg.sv
// Shared types and constants for the writeback stage: FSM states, load funct3 codes, XLEN.
package riscv_wb_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [0:0] {IDLE, WAIT_LOAD} wb_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of memory-stage inputs, data-memory response and register-file write port.
interface writeback_stage_if #(
   parameter int unsigned CNT_W = 32
);
   import riscv_wb_pkg::*;

   logic             valid_m;
   logic             reg_write_en_m;
   logic [4:0]       reg_write_addr_m;
   logic             reg_writedata_sel_m;
   logic [XLEN-1:0]  execute_out_m;
   logic [2:0]       load_funct3_m;
   logic             dmem_rvalid;
   logic [XLEN-1:0]  dmem_rdata;
   logic             reg_write_en_w;
   logic [4:0]       reg_write_addr_w;
   logic [XLEN-1:0]  reg_writedata_w;
   logic             stall_w;
   logic             load_err_w;
   logic             misalign_err_w;
   logic [CNT_W-1:0] retired_count_w;

   modport master (
      output valid_m, reg_write_en_m, reg_write_addr_m, reg_writedata_sel_m, execute_out_m,
             load_funct3_m, dmem_rvalid, dmem_rdata,
      input  reg_write_en_w, reg_write_addr_w, reg_writedata_w, stall_w, load_err_w,
             misalign_err_w, retired_count_w
   );

   modport slave (
      input  valid_m, reg_write_en_m, reg_write_addr_m, reg_writedata_sel_m, execute_out_m,
             load_funct3_m, dmem_rvalid, dmem_rdata,
      output reg_write_en_w, reg_write_addr_w, reg_writedata_w, stall_w, load_err_w,
             misalign_err_w, retired_count_w
   );

endinterface

// File: rtl/load_data_aligner.sv
// Combinational load formatter: picks the byte/half/word out of the read word, extends it,
// and flags addresses that are not naturally aligned for the access size.
module load_data_aligner
   import riscv_wb_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
      half_sel   = rdata[{addr_lo[1], 4'b0000} +: 16];
      data       = rdata;
      misaligned = 1'b0;
      case (funct3)
         F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
         F3_LBU: data = {24'b0, byte_sel};
         F3_LH: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = addr_lo[0];
         end
         F3_LHU: begin
            data       = {16'b0, half_sel};
            misaligned = addr_lo[0];
         end
         F3_LW:   misaligned = |addr_lo;
         // Unassigned encodings are treated as word loads
         default: misaligned = |addr_lo;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results immediately, waits on data memory for loads,
// drives the register-file write port, stalls upstream and counts retired instructions.
module writeback_stage
   import riscv_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 32
) (
   input logic              clk,
   input logic              rst,
   writeback_stage_if.slave wb
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   wb_state_e        state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q;
   logic [4:0]       ld_rd_q;
   logic             ld_we_q;
   logic [2:0]       ld_funct3_q;
   logic [1:0]       ld_addr_q;
   logic             we_w_q;
   logic [4:0]       addr_w_q;
   logic [XLEN-1:0]  data_w_q;
   logic             load_err_q;
   logic             misalign_q;
   logic [CNT_W-1:0] count_q;

   logic            timeout;
   logic            stall;
   logic            alu_retire;
   logic            load_accept;
   logic            misalign_retire;
   logic            load_done;
   logic            load_timeout;
   logic            rd_writes;
   logic [1:0]      align_addr;
   logic [2:0]      align_funct3;
   logic [XLEN-1:0] aligned_data;
   logic            misaligned;

   // In IDLE the aligner judges the incoming address; in WAIT_LOAD it formats the response.
   assign align_addr   = (state_q == IDLE) ? wb.execute_out_m[1:0] : ld_addr_q;
   assign align_funct3 = (state_q == IDLE) ? wb.load_funct3_m : ld_funct3_q;

   load_data_aligner u_aligner (
      .rdata     (wb.dmem_rdata),
      .addr_lo   (align_addr),
      .funct3    (align_funct3),
      .data      (aligned_data),
      .misaligned(misaligned)
   );

   assign timeout   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
   assign rd_writes = wb.reg_write_en_m && (wb.reg_write_addr_m != 5'd0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (wb.valid_m && wb.reg_writedata_sel_m && !misaligned) state_d = WAIT_LOAD;
         end
         WAIT_LOAD: begin
            if (wb.dmem_rvalid || timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      stall           = (state_q == WAIT_LOAD);
      alu_retire      = (state_q == IDLE) && wb.valid_m && !wb.reg_writedata_sel_m;
      load_accept     = (state_q == IDLE) && wb.valid_m && wb.reg_writedata_sel_m && !misaligned;
      misalign_retire = (state_q == IDLE) && wb.valid_m && wb.reg_writedata_sel_m && misaligned;
      load_done       = (state_q == WAIT_LOAD) && wb.dmem_rvalid;
      load_timeout    = (state_q == WAIT_LOAD) && !wb.dmem_rvalid && timeout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q    <= '0;
         ld_rd_q     <= '0;
         ld_we_q     <= 1'b0;
         ld_funct3_q <= '0;
         ld_addr_q   <= '0;
         we_w_q      <= 1'b0;
         addr_w_q    <= '0;
         data_w_q    <= '0;
         load_err_q  <= 1'b0;
         misalign_q  <= 1'b0;
         count_q     <= '0;
      end else begin
         we_w_q <= 1'b0;
         if (alu_retire && rd_writes) begin
            we_w_q   <= 1'b1;
            addr_w_q <= wb.reg_write_addr_m;
            data_w_q <= wb.execute_out_m;
         end
         if (load_done && ld_we_q) begin
            we_w_q   <= 1'b1;
            addr_w_q <= ld_rd_q;
            data_w_q <= aligned_data;
         end
         if (load_accept) begin
            ld_rd_q     <= wb.reg_write_addr_m;
            ld_we_q     <= rd_writes;
            ld_funct3_q <= wb.load_funct3_m;
            ld_addr_q   <= wb.execute_out_m[1:0];
            to_cnt_q    <= '0;
         end else if (stall) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
         end
         if (misalign_retire) misalign_q <= 1'b1;
         if (load_timeout)    load_err_q <= 1'b1;
         if (alu_retire || misalign_retire || load_done) count_q <= count_q + CNT_W'(1);
      end
   end

   assign wb.reg_write_en_w   = we_w_q;
   assign wb.reg_write_addr_w = addr_w_q;
   assign wb.reg_writedata_w  = data_w_q;
   assign wb.stall_w          = stall;
   assign wb.load_err_w       = load_err_q;
   assign wb.misalign_err_w   = misalign_q;
   assign wb.retired_count_w  = count_q;

endmodule
